// File: rtl/hub75_capture.sv
// HUB75 receive path: synchronizes the bus, captures shifted rows into a ping-pong
// line buffer and drains each latched line as top-half then bottom-half pixel writes.
module hub75_capture #(
    parameter int COLS     = 32,
    parameter int COLBITS  = 5,
    parameter int ADDRBITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hub_sclk,
    input  logic                hub_latch,
    input  logic                hub_blank,
    input  logic [ADDRBITS-1:0] hub_addr,
    input  logic [2:0]          hub_rgb0,
    input  logic [2:0]          hub_rgb1,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [ADDRBITS:0]   wr_row,
    output logic [COLBITS-1:0]  wr_col,
    output logic [2:0]          wr_rgb,
    output logic                line_done,
    output logic                frame_start,
    output logic                blank_q,
    output logic                overflow
);
    localparam int CW = COLBITS + 1;

    typedef enum logic [1:0] {IDLE, DRAIN_TOP, DRAIN_BOT, DONE} state_t;

    // Write handshake: a write transfers on any clk edge where wr_valid && wr_ready;
    // while wr_valid && !wr_ready, wr_row/wr_col/wr_rgb stay unchanged.

    logic [2:0]          sclk_s, latch_s;
    logic [1:0]          blank_s;
    logic [ADDRBITS-1:0] addr_s1, addr_s2, addr_e;
    logic [5:0]          rgb_s1, rgb_s2, rgb_e;
    logic                sclk_rise, latch_rise;

    state_t              state, state_n;
    logic [CW-1:0]       col, col_after, len;
    logic                cap_bank, drain_bank;
    logic [COLBITS-1:0]  c;
    logic [ADDRBITS-1:0] row;
    logic [5:0]          linebuf [2][COLS];
    logic [5:0]          pixel;
    logic                pix_we, latch_ok, last;

    // Data rides the same synchronizer depth as its strobes so both line up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_s     <= '0;
            latch_s    <= '0;
            blank_s    <= '0;
            addr_s1    <= '0;
            addr_s2    <= '0;
            rgb_s1     <= '0;
            rgb_s2     <= '0;
            sclk_rise  <= 1'b0;
            latch_rise <= 1'b0;
            addr_e     <= '0;
            rgb_e      <= '0;
        end else begin
            sclk_s     <= {sclk_s[1:0], hub_sclk};
            latch_s    <= {latch_s[1:0], hub_latch};
            blank_s    <= {blank_s[0], hub_blank};
            addr_s1    <= hub_addr;
            addr_s2    <= addr_s1;
            rgb_s1     <= {hub_rgb1, hub_rgb0};
            rgb_s2     <= rgb_s1;
            sclk_rise  <= sclk_s[1] & ~sclk_s[2];
            latch_rise <= latch_s[1] & ~latch_s[2];
            addr_e     <= addr_s2;
            rgb_e      <= rgb_s2;
        end
    end

    assign blank_q   = blank_s[1];
    assign pix_we    = sclk_rise && (col < CW'(COLS));
    assign col_after = pix_we ? col + CW'(1) : col;
    assign latch_ok  = latch_rise && (state == IDLE);

    always_ff @(posedge clk) begin
        if (pix_we) linebuf[cap_bank][col[COLBITS-1:0]] <= rgb_e;
    end

    // A pixel shifted in the latch cycle belongs to the line being latched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col      <= '0;
            cap_bank <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (latch_rise) begin
                col <= '0;
                if (latch_ok) cap_bank <= ~cap_bank;
                else          overflow <= 1'b1;
            end else if (pix_we) begin
                col <= col + CW'(1);
            end
            if (sclk_rise && !pix_we) overflow <= 1'b1;
        end
    end

    assign pixel = linebuf[drain_bank][c];
    assign last  = ({1'b0, c} == len - CW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len         <= '0;
            row         <= '0;
            drain_bank  <= 1'b0;
            c           <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= latch_ok && (addr_e == '0);
            if (latch_ok) begin
                len        <= col_after;
                row        <= addr_e;
                drain_bank <= cap_bank;
                c          <= '0;
            end else if (state == DRAIN_BOT && wr_ready && !last) begin
                c <= c + COLBITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        wr_valid  = 1'b0;
        wr_row    = {1'b0, row};
        wr_col    = c;
        wr_rgb    = pixel[2:0];
        line_done = 1'b0;
        case (state)
            IDLE: begin
                if (latch_ok) state_n = (col_after == '0) ? DONE : DRAIN_TOP;
            end
            DRAIN_TOP: begin
                wr_valid = 1'b1;
                if (wr_ready) state_n = DRAIN_BOT;
            end
            DRAIN_BOT: begin
                wr_valid = 1'b1;
                wr_row   = {1'b1, row};
                wr_rgb   = pixel[5:3];
                if (wr_ready) state_n = last ? DONE : DRAIN_TOP;
            end
            DONE: begin
                line_done = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_hub75_capture.sv
// Directed bench for hub75_capture: drives HUB75 lines, scoreboards the pixel writes.
module tb_hub75_capture;
    logic       clk = 0;
    logic       reset = 0;
    logic       hub_sclk = 0, hub_latch = 0, hub_blank = 0;
    logic [4:0] hub_addr = 0;
    logic [2:0] hub_rgb0 = 0, hub_rgb1 = 0;
    logic       wr_valid, wr_ready = 1;
    logic [5:0] wr_row;
    logic [4:0] wr_col;
    logic [2:0] wr_rgb;
    logic       line_done, frame_start, blank_q, overflow;

    logic [13:0] exp_q[$];
    int n_checks = 0, n_pass = 0, n_fail = 0;
    int ld_cnt = 0, fs_cnt = 0, fs_ld_cnt = 0, n_writes = 0;

    hub75_capture #(.COLS(32), .COLBITS(5), .ADDRBITS(5)) dut (
        .clk(clk), .reset(reset), .hub_sclk(hub_sclk), .hub_latch(hub_latch),
        .hub_blank(hub_blank), .hub_addr(hub_addr), .hub_rgb0(hub_rgb0),
        .hub_rgb1(hub_rgb1), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_col(wr_col), .wr_rgb(wr_rgb), .line_done(line_done),
        .frame_start(frame_start), .blank_q(blank_q), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write (and every stalled cycle) is checked against the queue head.
    always @(negedge clk) begin
        if (wr_valid) begin
            chk("write_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                if (wr_ready) begin
                    chk("write", {18'd0, wr_row, wr_col, wr_rgb}, {18'd0, exp_q[0]});
                    void'(exp_q.pop_front());
                    n_writes++;
                end else begin
                    chk("hold", {18'd0, wr_row, wr_col, wr_rgb}, {18'd0, exp_q[0]});
                end
            end
        end
        if (line_done) begin
            ld_cnt++;
            chk("done_q_empty", exp_q.size(), 0);
        end
        if (frame_start) fs_cnt++;
        if (frame_start && line_done) fs_ld_cnt++;
    end

    task automatic shift_px(input logic [2:0] r0, input logic [2:0] r1);
        @(posedge clk); #1;
        hub_rgb0 = r0;
        hub_rgb1 = r1;
        repeat (2) @(posedge clk);
        #1 hub_sclk = 1;
        repeat (3) @(posedge clk);
        #1 hub_sclk = 0;
    endtask

    // kind 0: rgb0=col[2:0], rgb1=~col[2:0]; kind 1: random colours.
    task automatic send_line(input int n, input logic [4:0] addr, input int kind, input bit expect_it);
        logic [2:0] r0, r1;
        for (int i = 0; i < n; i++) begin
            if (kind == 0) begin
                r0 = 3'(i);
                r1 = ~r0;
            end else begin
                r0 = 3'($urandom_range(0, 7));
                r1 = 3'($urandom_range(0, 7));
            end
            if (expect_it && i < 32) begin
                exp_q.push_back({1'b0, addr, 5'(i), r0});
                exp_q.push_back({1'b1, addr, 5'(i), r1});
            end
            shift_px(r0, r1);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic latch_line(input logic [4:0] addr, input bit check_lat);
        @(posedge clk); #1;
        hub_addr  = addr;
        hub_latch = 1;
        if (check_lat) begin
            repeat (3) @(posedge clk);
            #1 chk("latency_3clk_low", wr_valid, 0);
            @(posedge clk);
            #1 chk("latency_4clk_high", wr_valid, 1);
        end else begin
            repeat (4) @(posedge clk);
            #1;
        end
        hub_latch = 0;
    endtask

    function automatic logic ready_for(input int mode, input int i);
        logic [3:0] pat;
        pat = 4'b1001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[3 - (i % 4)];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic drain(input int mode, input int ld_target);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #1;
            wr_ready = ready_for(mode, i);
            if (exp_q.size() == 0 && ld_cnt >= ld_target) ok = 1;
        end
        wr_ready = 1;
        chk("drain_done", 32'(ok), 1);
    endtask

    int ld0, fs0, w0, fsld0;
    bit seen;

    initial begin
        // reset state
        hub_blank = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_blank_q", blank_q, 0);
        reset = 1;
        repeat (3) @(posedge clk);
        #1 chk("blank_sync", blank_q, 1);
        hub_blank = 0;
        repeat (3) @(posedge clk);
        #1 chk("blank_clear", blank_q, 0);

        // full line, addr 5, ready held high
        send_line(32, 5'd5, 0, 1);
        w0 = n_writes;
        latch_line(5'd5, 1);
        drain(0, 1);
        chk("t1_writes", n_writes - w0, 64);
        chk("t1_line_done", ld_cnt, 1);
        chk("t1_no_frame_start", fs_cnt, 0);
        chk("t1_overflow", overflow, 0);

        // same line with 1-0-0-1 stalls
        send_line(32, 5'd5, 0, 1);
        w0 = n_writes;
        latch_line(5'd5, 0);
        drain(1, 2);
        chk("t2_writes", n_writes - w0, 64);
        chk("t2_line_done", ld_cnt, 2);

        // empty line at address 0
        w0 = n_writes;
        fs0 = fs_cnt;
        fsld0 = fs_ld_cnt;
        latch_line(5'd0, 0);
        drain(0, 3);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_no_writes", n_writes - w0, 0);
        chk("t3_frame_start", fs_cnt - fs0, 1);
        chk("t3_fs_with_done", fs_ld_cnt - fsld0, 1);
        chk("t3_line_done", ld_cnt, 3);
        chk("t3_overflow", overflow, 0);

        // 34 shifts: extras dropped, overflow set
        send_line(34, 5'd3, 0, 1);
        #1 chk("t4_overflow_set", overflow, 1);
        w0 = n_writes;
        latch_line(5'd3, 0);
        drain(0, 4);
        chk("t4_writes", n_writes - w0, 64);

        // clean line afterwards: overflow is sticky
        send_line(32, 5'd6, 1, 1);
        latch_line(5'd6, 0);
        drain(2, 5);
        chk("t4_overflow_sticky", overflow, 1);

        // reset in the middle of a drain
        send_line(32, 5'd2, 1, 1);
        latch_line(5'd2, 0);
        repeat (20) @(posedge clk);
        ld0 = ld_cnt;
        @(posedge clk);
        #3 reset = 0;
        #1 chk("mid_rst_valid_drop", wr_valid, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_done", ld_cnt, ld0);
        chk("mid_rst_overflow", overflow, 0);
        reset = 1;
        send_line(32, 5'd4, 1, 1);
        w0 = n_writes;
        latch_line(5'd4, 0);
        drain(2, ld0 + 1);
        chk("post_rst_writes", n_writes - w0, 64);

        // second latch while the first line is stalled in drain
        wr_ready = 0;
        send_line(32, 5'd7, 1, 1);
        w0 = n_writes;
        ld0 = ld_cnt;
        latch_line(5'd7, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (wr_valid) seen = 1;
        end
        chk("t5_drain_started", 32'(seen), 1);
        chk("t5_overflow_before", overflow, 0);
        send_line(32, 5'd9, 1, 0);
        latch_line(5'd9, 0);
        repeat (2) @(posedge clk);
        #1 chk("t5_overflow_set", overflow, 1);
        drain(0, ld0 + 1);
        repeat (60) @(posedge clk);
        #1;
        chk("t5_writes", n_writes - w0, 64);
        chk("t5_one_line", ld_cnt, ld0 + 1);
        chk("t5_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hub75_capture.md
Name: hub75_capture

Overview:
- Receive-side counterpart of the panel driver: samples a HUB75 bus (sclk, latch, blank, addr, rgb0/rgb1) from an external controller or our own output stage in loopback.
- Reconstructs shifted rows into a stream of pixel writes for a framebuffer write port.
- Sits between the HUB75 input pins and the framebuffer/streaming logic.
- Uses a ping-pong line buffer: one line is captured while the previous one drains.

Parameters:
- COLS, 32, pixels per shifted line; max sclk pulses per latch.
- COLBITS, 5, width of the column index; must satisfy 2^COLBITS >= COLS.
- ADDRBITS, 5, width of the HUB75 row address bus.

Ports:
- clk  input  1  system clock; must run at >= 4x the HUB75 sclk rate.
- reset  input  1  asynchronous, active-low reset.
- hub_sclk  input  1  HUB75 shift clock, asynchronous to clk.
- hub_latch  input  1  HUB75 latch, asynchronous.
- hub_blank  input  1  HUB75 blank/OE, asynchronous.
- hub_addr  input  ADDRBITS  HUB75 row address.
- hub_rgb0  input  3  upper-half pixel data.
- hub_rgb1  input  3  lower-half pixel data.
- wr_valid  output  1  pixel write valid.
- wr_ready  input  1  sink accepts the write.
- wr_row  output  ADDRBITS+1  panel row; MSB=0 selects the upper half, MSB=1 the lower half.
- wr_col  output  COLBITS  column index.
- wr_rgb  output  3  pixel colour.
- line_done  output  1  one-cycle pulse after the last write of a line.
- frame_start  output  1  one-cycle pulse when a line with address 0 begins draining.
- blank_q  output  1  synchronized hub_blank.
- overflow  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous): wr_valid, line_done, frame_start, overflow and blank_q go to 0; blank_q=0 means "not blanked". Column counter=0, capture bank=0, drain FSM=IDLE, synchronizers cleared.
- Synchronization: every hub_* input passes through a 2-FF synchronizer. Edges are detected by comparing the 2nd stage against a 3rd delayed copy.
- Data sampling: hub_addr, hub_rgb0 and hub_rgb1 are taken from the same synchronizer stage as sclk and latch, so data and its strobe stay aligned.
- Capture path (runs independently of the drain FSM):
  - On an sclk rising edge with col < COLS: write {rgb1,rgb0} into linebuf[capture_bank][col] and increment col.
  - On an sclk rising edge with col == COLS: drop the data and set overflow.
- Latch rising edge:
  - If the FSM is IDLE: record len=col and row=hub_addr, swap banks (drain bank = old capture bank), reset col to 0, enter DRAIN_TOP with c=0.
  - If the FSM is not IDLE: set overflow, discard the captured line (no bank swap), reset col to 0.
- If sclk and latch edges are detected in the same cycle, the sclk edge is processed first; its pixel belongs to the line being latched.
- Drain FSM states: IDLE, DRAIN_TOP, DRAIN_BOT, DONE.
  - Entry with len==0: go straight to DONE; no writes are issued.
  - DRAIN_TOP: wr_valid=1, wr_row={1'b0,row}, wr_col=c, wr_rgb=rgb0 of entry c. On wr_valid&&wr_ready, go to DRAIN_BOT.
  - DRAIN_BOT: wr_valid=1, wr_row={1'b1,row}, wr_col=c, wr_rgb=rgb1 of entry c. On a handshake: if c==len-1 go to DONE, else c++ and go to DRAIN_TOP.
  - DONE: line_done=1 for exactly one cycle, then IDLE.
- Handshake rules:
  - wr_valid is registered and asserts in the cycle after the latch edge is detected.
  - While wr_valid=1 and wr_ready=0, wr_row, wr_col and wr_rgb are held stable.
  - Back-to-back handshakes are allowed at one write per cycle.
- frame_start pulses together with the first cycle of DRAIN_TOP (or DONE when len==0) when the latched row==0.
- blank_q is the 2nd synchronizer stage of hub_blank and is informational only; capture does not depend on blank.
- Latency:
  - From the hub_latch pin rising to the first wr_valid is 4 clk cycles: 2 sync + 1 edge + 1 register.
  - Draining a full line takes 2*len cycles with wr_ready held at 1.
- Reset mid-drain aborts immediately and never produces a partial line_done.

Test Plan:
- 32 sclk pulses with rgb0=col[2:0] and rgb1=~col[2:0], then latch with addr=5 -> 64 writes alternating rows 5/37, cols 0..31, matching data, then one line_done; overflow=0.
- Same line with wr_ready toggled 1-0-0-1 -> outputs held while stalled; write order and count unchanged; no pixels lost.
- Latch with addr=0 after 0 sclks -> no wr_valid, frame_start and line_done pulse in the same cycle; overflow stays 0.
- 34 sclks then latch -> only cols 0..31 written; overflow=1 and stays 1 until reset.
- Second latch arriving while the first line is draining with wr_ready=0 -> overflow=1; the drain finishes with the first line's data; the second line is never emitted.
- Assert reset=0 midway through a 64-write drain -> wr_valid drops asynchronously; no line_done; after release, a fresh line captures correctly from col 0.
